// File: rtl/rx_datapath.sv
// UART receive datapath: line synchroniser, start-edge detector, 11-bit frame
// shift register, parity check and stop/start validation for an external receive FSM.
module rx_datapath #(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       run_shift,
    input  logic       sample_done,
    input  logic       parity_load,
    input  logic       chk_stop,
    output logic       start_bit_detected,
    output logic       parity_error,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error
);

    logic        rx_meta;
    logic        rx_s;
    logic        rx_d;
    logic [1:0]  sync_fill;
    logic        armed;
    logic        busy;
    logic [10:0] sr;
    logic        start_cond;
    logic        frame_ok;

    // Reset preloads the synchroniser with idle-high values, so a line held low
    // across reset would look like a falling edge. The line must first be seen high
    // as a real sample before a start edge is accepted.
    assign start_cond = armed & rx_d & ~rx_s & ~busy;
    assign frame_ok   = sr[10] & ~sr[0];

    assign parity_error = parity_load & ((^sr[9:1]) != PARITY_ODD);

    // NOTE: every sequential assignment is non-blocking so all flops sample the
    // pre-edge values; a blocking assignment here would collapse the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_d      <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            rx_meta   <= rx_in;
            rx_s      <= rx_meta;
            rx_d      <= rx_s;
            sync_fill <= {sync_fill[0], 1'b1};
            armed     <= armed | (sync_fill[1] & rx_s);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_bit_detected <= 1'b0;
            busy               <= 1'b0;
        end else begin
            start_bit_detected <= start_cond;
            if (start_cond) begin
                busy <= 1'b1;
            end else if (chk_stop || parity_error) begin
                busy <= 1'b0;
            end
        end
    end

    // Clearing on the start edge takes priority so a new frame never inherits stale bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else if (start_cond) begin
            sr <= '0;
        end else if (run_shift && sample_done) begin
            sr <= {rx_s, sr[10:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out    <= 8'h00;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            data_valid  <= chk_stop & frame_ok;
            frame_error <= chk_stop & ~frame_ok;
            if (chk_stop && frame_ok) begin
                data_out <= sr[8:1];
            end
        end
    end

endmodule

// File: tb/tb_rx_datapath.sv
// Self-checking bench for rx_datapath: an even-parity and an odd-parity instance
// share one serial line; the bench plays the receive FSM and predicts every result.
module tb_rx_datapath;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic       run_shift;
    logic       sample_done;
    logic       parity_load;
    logic       chk_stop_e;
    logic       chk_stop_o;

    logic       e_start, e_perr, e_valid, e_ferr;
    logic [7:0] e_data;
    logic       o_start, o_perr, o_valid, o_ferr;
    logic [7:0] o_data;

    rx_datapath #(.PARITY_ODD(1'b0)) dut_even (
        .clk                (clk),
        .rst                (rst),
        .rx_in              (rx_in),
        .run_shift          (run_shift),
        .sample_done        (sample_done),
        .parity_load        (parity_load),
        .chk_stop           (chk_stop_e),
        .start_bit_detected (e_start),
        .parity_error       (e_perr),
        .data_out           (e_data),
        .data_valid         (e_valid),
        .frame_error        (e_ferr)
    );

    rx_datapath #(.PARITY_ODD(1'b1)) dut_odd (
        .clk                (clk),
        .rst                (rst),
        .rx_in              (rx_in),
        .run_shift          (run_shift),
        .sample_done        (sample_done),
        .parity_load        (parity_load),
        .chk_stop           (chk_stop_o),
        .start_bit_detected (o_start),
        .parity_error       (o_perr),
        .data_out           (o_data),
        .data_valid         (o_valid),
        .frame_error        (o_ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic       perr_e;
        logic       perr_o;
        logic       dv_e;
        logic       fe_e;
        logic       dv_o;
        logic       fe_o;
    } vec_t;

    int vectors     = 0;
    int miscompares = 0;

    int starts_e = 0, starts_o = 0;
    int pulses_e = 0, pulses_o = 0;
    int both_e   = 0, both_o   = 0;

    logic [7:0] exp_data_e = 8'h00;
    logic [7:0] exp_data_o = 8'h00;

    // Output pulses are tallied just after each rising edge, away from the
    // falling edge where the main sequence drives and checks.
    always @(posedge clk) begin
        #1;
        if (e_start) starts_e++;
        if (o_start) starts_o++;
        if (e_valid || e_ferr) pulses_e++;
        if (o_valid || o_ferr) pulses_o++;
        if (e_valid && e_ferr) both_e++;
        if (o_valid && o_ferr) both_o++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic model_perr(input logic [7:0] d, input logic p, input logic odd);
        return (($countones({d, p}) % 2) != int'(odd));
    endfunction

    // One 8-cycle bit window; the strobe lands mid-window after the sync delay.
    // With noise set, a stray sample_done arrives while run_shift is low.
    task automatic drive_bit(input logic b, input logic noise);
        rx_in = b;
        tick();
        if (noise) begin
            run_shift   = 1'b0;
            sample_done = 1'b1;
            tick();
            sample_done = 1'b0;
            run_shift   = 1'b1;
        end else begin
            tick();
        end
        repeat (2) tick();
        sample_done = 1'b1;
        tick();
        sample_done = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input logic noise,
                              input logic x_perr_e, input logic x_perr_o,
                              input logic x_dv_e, input logic x_fe_e,
                              input logic x_dv_o, input logic x_fe_o,
                              input string tag);
        logic [10:0] bits;
        int          s0e, s0o;
        bits = {s, p, d, 1'b0};
        s0e  = starts_e;
        s0o  = starts_o;
        run_shift = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive_bit(bits[i], noise);
        end
        run_shift = 1'b0;
        rx_in     = 1'b1;

        parity_load = 1'b1;
        #1;
        check({tag, " perr_even"}, 32'(e_perr), 32'(x_perr_e));
        check({tag, " perr_odd"},  32'(o_perr), 32'(x_perr_o));
        tick();
        parity_load = 1'b0;

        chk_stop_e = ~x_perr_e;
        chk_stop_o = ~x_perr_o;
        tick();
        chk_stop_e = 1'b0;
        chk_stop_o = 1'b0;

        if (x_dv_e) exp_data_e = d;
        if (x_dv_o) exp_data_o = d;
        check({tag, " valid_even"}, 32'(e_valid), 32'(x_dv_e));
        check({tag, " ferr_even"},  32'(e_ferr),  32'(x_fe_e));
        check({tag, " data_even"},  32'(e_data),  32'(exp_data_e));
        check({tag, " valid_odd"},  32'(o_valid), 32'(x_dv_o));
        check({tag, " ferr_odd"},   32'(o_ferr),  32'(x_fe_o));
        check({tag, " data_odd"},   32'(o_data),  32'(exp_data_o));
        tick();
        check({tag, " valid_even_drop"}, 32'(e_valid), 32'd0);
        check({tag, " ferr_even_drop"},  32'(e_ferr),  32'd0);
        check({tag, " valid_odd_drop"},  32'(o_valid), 32'd0);
        check({tag, " ferr_odd_drop"},   32'(o_ferr),  32'd0);
        check({tag, " perr_even_idle"},  32'(e_perr),  32'd0);
        check({tag, " perr_odd_idle"},   32'(o_perr),  32'd0);
        check({tag, " starts_even"}, 32'(starts_e - s0e), 32'd1);
        check({tag, " starts_odd"},  32'(starts_o - s0o), 32'd1);
    endtask

    task automatic apply_reset(input logic line);
        rst         = 1'b1;
        rx_in       = line;
        run_shift   = 1'b0;
        sample_done = 1'b0;
        parity_load = 1'b0;
        chk_stop_e  = 1'b0;
        chk_stop_o  = 1'b0;
        repeat (2) tick();
        exp_data_e = 8'h00;
        exp_data_o = 8'h00;
        rst = 1'b0;
    endtask

    vec_t       tbl [10];
    logic [7:0] rd;
    logic       rp, rs, rn, pe, po;
    int         s0, p0;

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{8'h7E, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state
        apply_reset(1'b1);
        rst = 1'b1;
        tick();
        check("rst start_even", 32'(e_start), 32'd0);
        check("rst valid_even", 32'(e_valid), 32'd0);
        check("rst ferr_even",  32'(e_ferr),  32'd0);
        check("rst data_even",  32'(e_data),  32'h00);
        check("rst perr_even",  32'(e_perr),  32'd0);
        check("rst start_odd",  32'(o_start), 32'd0);
        check("rst valid_odd",  32'(o_valid), 32'd0);
        check("rst ferr_odd",   32'(o_ferr),  32'd0);
        check("rst data_odd",   32'(o_data),  32'h00);
        check("rst perr_odd",   32'(o_perr),  32'd0);
        rst = 1'b0;
        repeat (6) tick();

        // Directed frames
        for (int i = 0; i < 10; i++) begin
            send_frame(tbl[i].d, tbl[i].p, tbl[i].s, 1'b0,
                       tbl[i].perr_e, tbl[i].perr_o,
                       tbl[i].dv_e, tbl[i].fe_e, tbl[i].dv_o, tbl[i].fe_o,
                       $sformatf("tbl%0d", i));
            repeat (3) tick();
        end

        // Reset after five data bits, then a clean 0x81 frame
        run_shift = 1'b1;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive_bit(((8'h81 >> i) & 8'h01) != 0, 1'b0);
        apply_reset(1'b1);
        p0 = pulses_e + pulses_o;
        repeat (6) tick();
        check("midrst data_even", 32'(e_data), 32'h00);
        check("midrst data_odd",  32'(o_data), 32'h00);
        check("midrst no_pulses", 32'(pulses_e + pulses_o - p0), 32'd0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "midrst_81");
        check("midrst one_pulse", 32'(pulses_e + pulses_o - p0), 32'd1);
        repeat (3) tick();

        // Line held low through reset release: no start until it rises and falls
        apply_reset(1'b0);
        s0 = starts_e + starts_o;
        repeat (20) tick();
        check("low_after_rst no_start", 32'(starts_e + starts_o - s0), 32'd0);
        rx_in = 1'b1;
        repeat (6) tick();
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "low_after_rst");

        // Random frames, back-to-back or with short gaps, some with stray strobes
        for (int n = 0; n < 40; n++) begin
            rd = 8'($urandom);
            rp = 1'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            rn = 1'($urandom);
            pe = model_perr(rd, rp, 1'b0);
            po = model_perr(rd, rp, 1'b1);
            send_frame(rd, rp, rs, rn, pe, po, ~pe & rs, ~pe & ~rs, ~po & rs, ~po & ~rs,
                       $sformatf("rand%0d d=%02h p=%0b s=%0b", n, rd, rp, rs));
            repeat ($urandom_range(0, 3)) tick();
        end

        check("valid_ferr_overlap_even", 32'(both_e), 32'd0);
        check("valid_ferr_overlap_odd",  32'(both_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
